// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_pkg                                                |
// | Description : Shared op codes, FSM state encoding and helpers for    |
// |               the sequential ALU (alu_seq) and its mul/div engine.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_NOR   = 4'd4;
  localparam logic [3:0] OP_SRL   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MULLO = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  // Ops that run through the iterative engine (divide-by-zero is filtered
  // separately by the caller because it completes in one cycle).
  function automatic logic is_iterative(input logic [3:0] op);
    return (op >= OP_MULLO) && (op <= OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_muldiv_iter                                        |
// | Description : Iterative unsigned shift-add multiplier / restoring    |
// |               divider, one bit per clock, MSB first.                 |
// | Ports       : clk, rst_n (async low), load (start new op), is_div,   |
// |               a, b (operands), busy, last (final step this edge),    |
// |               result_lo/result_hi (product halves or quot/rem).      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 2);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi_q, lo_q, sh_q, d_q;
  logic             div_q;

  logic [WIDTH-1:0]   cur_hi, cur_lo, cur_sh, cur_d;
  logic               cur_div;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     rem_shift;
  logic               ge;
  logic [WIDTH-1:0]   rem_diff, next_hi, next_lo;

  // WIDTH bit-steps must fit into WIDTH-1 clock edges after the load edge,
  // so the load edge itself performs step 0 on the freshly presented
  // operands, and the final step is taken straight off the step logic into
  // the caller's result register.
  assign cur_hi  = load ? '0 : hi_q;
  assign cur_lo  = load ? (is_div ? a : '0) : lo_q;
  assign cur_sh  = load ? b : sh_q;
  assign cur_d   = load ? (is_div ? b : a) : d_q;
  assign cur_div = load ? is_div : div_q;

  // Multiply: acc = 2*acc + (next multiplier bit ? multiplicand : 0)
  assign prod = {cur_hi[WIDTH-2:0], cur_lo, 1'b0}
              + {{WIDTH{1'b0}}, (cur_sh[WIDTH-1] ? cur_d : {WIDTH{1'b0}})};

  // Divide: hi holds the partial remainder, lo shifts the dividend out and
  // the quotient bits in. The difference always fits WIDTH bits when taken.
  assign rem_shift = {cur_hi, cur_lo[WIDTH-1]};
  assign ge        = rem_shift >= {1'b0, cur_d};
  assign rem_diff  = rem_shift[WIDTH-1:0] - cur_d;

  assign next_hi = cur_div ? (ge ? rem_diff : rem_shift[WIDTH-1:0]) : prod[2*WIDTH-1:WIDTH];
  assign next_lo = cur_div ? {cur_lo[WIDTH-2:0], ge} : prod[WIDTH-1:0];

  assign result_hi = next_hi;
  assign result_lo = next_lo;
  assign last      = busy && (count == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      count <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      sh_q  <= '0;
      d_q   <= '0;
      div_q <= 1'b0;
    end else begin
      if (load || busy) begin
        hi_q <= next_hi;
        lo_q <= next_lo;
        sh_q <= {cur_sh[WIDTH-2:0], 1'b0};
      end
      if (load) begin
        busy  <= 1'b1;
        count <= '0;
        d_q   <= cur_d;
        div_q <= is_div;
      end else if (busy) begin
        count <= count + CW'(1);
        if (last) busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_seq                                                |
// | Description : Multicycle ALU: single-cycle logic/add/shift/compare   |
// |               plus iterative unsigned mul/div behind start/done.     |
// | Ports       : clk, rst_n (async low), start, op[3:0], A, B (inputs); |
// |               busy, done (1-cycle pulse), res, zero, overflow.       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             overflow
);

  state_t           state;
  logic             sel_hi;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, diff, single_res, iter_res;
  logic [WIDTH-1:0] iter_lo, iter_hi;
  logic             single_ovf, is_div_op, go_iter, load;
  logic             iter_busy, iter_last;

  assign shamt     = B[SHW-1:0];
  assign sum       = A + B;
  assign diff      = A - B;
  assign is_div_op = (op == OP_DIVU) || (op == OP_REMU);
  // Divide by zero bypasses the engine and completes like a single-cycle op.
  assign go_iter   = is_iterative(op) && !(is_div_op && (B == '0));
  assign load      = (state == ST_IDLE) && start && go_iter;

  always_comb begin
    single_res = '0;
    single_ovf = 1'b0;
    case (op)
      OP_AND: single_res = A & B;
      OP_OR:  single_res = A | B;
      OP_ADD: begin
        single_res = sum;
        single_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_XOR: single_res = A ^ B;
      OP_NOR: single_res = ~(A | B);
      OP_SRL: single_res = A >> shamt;
      OP_SUB: begin
        single_res = diff;
        single_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL:  single_res = A << shamt;
      OP_SRA:  single_res = $unsigned($signed(A) >>> shamt);
      OP_DIVU: single_res = '1;  // only selected when B == 0
      OP_REMU: single_res = A;   // only selected when B == 0
      default: single_res = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .is_div    (is_div_op),
    .a         (A),
    .b         (B),
    .busy      (iter_busy),
    .last      (iter_last),
    .result_lo (iter_lo),
    .result_hi (iter_hi)
  );

  // MULHU (11) and REMU (13) are the odd codes and both want the high half.
  assign iter_res = sel_hi ? iter_hi : iter_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      res      <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      sel_hi   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (go_iter) begin
              state  <= is_div_op ? ST_DIV : ST_MUL;
              busy   <= 1'b1;
              sel_hi <= op[0];
            end else begin
              res      <= single_res;
              zero     <= (single_res == '0);
              overflow <= single_ovf;
              done     <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (iter_busy && iter_last) begin
            res      <= iter_res;
            zero     <= (iter_res == '0);
            overflow <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
